// File: rtl/runner_pkg.sv
// runner_pkg: shared types, constants and box-overlap helper for the runner engine.
package runner_pkg;

    localparam int unsigned COORD_BITS = 10;

    typedef logic [COORD_BITS-1:0] coord_t;

    typedef enum logic [1:0] {
        READY   = 2'd0,
        PLAYING = 2'd1,
        OVER    = 2'd2
    } game_state_t;

    localparam logic [7:0] KEY_SPACE = 8'h2C;

    // Inclusive axis-aligned box overlap; a point is a box with zero extent.
    function automatic logic box_overlap(
        input int unsigned ax, input int unsigned aw,
        input int unsigned ay, input int unsigned ah,
        input int unsigned bx, input int unsigned bw,
        input int unsigned by, input int unsigned bh
    );
        return (ax <= bx + bw) && (bx <= ax + aw) &&
               (ay + ah >= by) && (ay <= by + bh);
    endfunction

endpackage

// File: rtl/runner_obstacle.sv
// runner_obstacle: one scrolling obstacle lane; wraps to the right edge when it
// passes the left edge and flags a score increment on that tick.
module runner_obstacle
    import runner_pkg::*;
#(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned INIT_X   = 640
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               tick,
    input  logic               advance,
    input  logic               restart,
    input  logic [COORD_W-1:0] speed,
    output logic [COORD_W-1:0] x,
    output logic               pass_c
);

    // Lane passes (and wraps) when it is within one step of the left edge.
    assign pass_c = tick && advance && (x <= speed);

    // Lane position: restart, wrap or scroll left, only on frame ticks.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x <= COORD_W'(INIT_X);
        end else if (tick) begin
            if (restart) begin
                x <= COORD_W'(INIT_X);
            end else if (advance) begin
                if (x <= speed) begin
                    x <= COORD_W'(SCREEN_W - 1);
                end else begin
                    x <= x - speed;
                end
            end
        end
    end

endmodule

// File: rtl/runner_engine.sv
// runner_engine: player/obstacle game engine with READY/PLAYING/OVER control,
// collision detection, saturating score and per-pixel hit flags.
// Optional build macro RUNNER_SPEEDUP_EN: raise obstacle speed every 8 points up
// to MAX_SPEED; when undefined the speed stays at OBST_SPEED.
module runner_engine
    import runner_pkg::*;
#(
    parameter int unsigned NUM_OBST     = 2,
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned DINO_X       = 160,
    parameter int unsigned GROUND_Y     = 430,
    parameter int unsigned DINO_W       = 20,
    parameter int unsigned DINO_H       = 40,
    parameter int unsigned OBST_Y       = 425,
    parameter int unsigned OBST_W       = 15,
    parameter int unsigned OBST_H       = 45,
    parameter int unsigned OBST_SPACING = 320,
    parameter int unsigned OBST_SPEED   = 2,
    parameter int unsigned JUMP_V0      = 12,
    parameter int unsigned GRAVITY      = 1,
    parameter int unsigned MAX_SPEED    = 6
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic [7:0]         keycode,
    output logic               is_dino,
    output logic               is_obst,
    output logic               game_over,
    output logic [15:0]        score,
    output logic [COORD_W-1:0] dino_y
);

    localparam int unsigned VW    = COORD_W + 1;
    localparam int unsigned CNT_W = 3;

    game_state_t               state;
    logic [2:0]                fsync;
    logic                      tick;
    logic                      key_prev;
    logic                      space_now;
    logic                      space_edge;
    logic signed [VW-1:0]      vy;
    logic                      grounded;
    logic [COORD_W-1:0]        speed;

    logic [COORD_W-1:0]        lane_x [NUM_OBST];
    logic [NUM_OBST-1:0]       lane_pass;
    logic [NUM_OBST-1:0]       lane_hit;
    logic [NUM_OBST-1:0]       lane_pix;
    logic                      collide;
    logic                      advance;
    logic                      restart;

    logic [CNT_W-1:0]          pass_cnt;
    logic [16:0]               score_sum;
    logic [15:0]               score_next;
    logic                      speed_up;

    logic signed [VW-1:0]      vy_eff;
    logic signed [VW-1:0]      y_next;
    logic                      air;
    logic                      land;

    // Frame strobe synchroniser plus rising-edge detect history.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fsync <= '0;
        end else begin
            fsync <= {fsync[1:0], frame_clk};
        end
    end

    assign tick       = fsync[1] & ~fsync[2];
    assign space_now  = (keycode == KEY_SPACE);
    assign space_edge = tick && space_now && !key_prev;

    // Space level as seen on the previous tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            key_prev <= 1'b0;
        end else if (tick) begin
            key_prev <= space_now;
        end
    end

    assign collide = |lane_hit;
    assign advance = tick && (state == PLAYING) && !collide;
    assign restart = tick && (state == OVER) && space_edge;

    // Obstacle lanes, each spaced to the right of the previous one.
    for (genvar i = 0; i < NUM_OBST; i++) begin : g_lane
        runner_obstacle #(
            .COORD_W  (COORD_W),
            .SCREEN_W (SCREEN_W),
            .INIT_X   (SCREEN_W + i * OBST_SPACING)
        ) u_obst (
            .Clk     (Clk),
            .Reset   (Reset),
            .tick    (tick),
            .advance (advance),
            .restart (restart),
            .speed   (speed),
            .x       (lane_x[i]),
            .pass_c  (lane_pass[i])
        );

        assign lane_hit[i] = box_overlap(DINO_X, DINO_W, 32'(dino_y), DINO_H,
                                         32'(lane_x[i]), OBST_W, OBST_Y, OBST_H);

        assign lane_pix[i] = (32'(lane_x[i]) < SCREEN_W) &&
                             box_overlap(32'(DrawX), 0, 32'(DrawY), 0,
                                         32'(lane_x[i]), OBST_W, OBST_Y, OBST_H);
    end

    // Count passing lanes and form the saturated score.
    always_comb begin
        pass_cnt = '0;
        for (int i = 0; i < NUM_OBST; i++) begin
            pass_cnt = pass_cnt + CNT_W'(lane_pass[i]);
        end
        score_sum  = {1'b0, score} + 17'(pass_cnt);
        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

`ifdef RUNNER_SPEEDUP_EN
    // Speed steps up when the score enters a new block of eight.
    assign speed_up = (score_next[15:3] != score[15:3]) &&
                      (speed < COORD_W'(MAX_SPEED));
`else
    logic unused_max_speed;
    assign unused_max_speed = (MAX_SPEED != 0);
    assign speed_up         = 1'b0;
`endif

    // Player vertical motion candidate for this tick.
    always_comb begin
        vy_eff = vy;
        air    = !grounded;
        if (grounded && space_now) begin
            vy_eff = VW'(JUMP_V0);
            air    = 1'b1;
        end
        y_next = $signed({1'b0, dino_y}) - vy_eff;
        land   = (y_next >= $signed(VW'(GROUND_Y)));
    end

    // Game state machine and player/score registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= READY;
            dino_y    <= COORD_W'(GROUND_Y);
            vy        <= '0;
            grounded  <= 1'b1;
            score     <= '0;
            speed     <= COORD_W'(OBST_SPEED);
            game_over <= 1'b0;
        end else if (tick) begin
            case (state)
                READY: begin
                    if (space_edge) begin
                        state <= PLAYING;
                    end
                end
                PLAYING: begin
                    if (collide) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        if (air) begin
                            if (land) begin
                                dino_y   <= COORD_W'(GROUND_Y);
                                vy       <= '0;
                                grounded <= 1'b1;
                            end else begin
                                dino_y   <= y_next[COORD_W-1:0];
                                vy       <= vy_eff - VW'(GRAVITY);
                                grounded <= 1'b0;
                            end
                        end
                        score <= score_next;
                        if (speed_up) begin
                            speed <= speed + COORD_W'(1);
                        end
                    end
                end
                OVER: begin
                    if (space_edge) begin
                        state     <= PLAYING;
                        game_over <= 1'b0;
                        dino_y    <= COORD_W'(GROUND_Y);
                        vy        <= '0;
                        grounded  <= 1'b1;
                        score     <= '0;
                        speed     <= COORD_W'(OBST_SPEED);
                    end
                end
                default: begin
                    state <= READY;
                end
            endcase
        end
    end

    // Per-pixel hit flags against the registered positions.
    assign is_dino = box_overlap(32'(DrawX), 0, 32'(DrawY), 0,
                                 DINO_X, DINO_W, 32'(dino_y), DINO_H);
    assign is_obst = |lane_pix;

endmodule

// File: tb/tb_runner_engine.sv
// tb_runner_engine: directed and randomized frames checked against a frame-level
// behavioural model of the runner game.
module tb_runner_engine;

    localparam logic [7:0] SP = 8'h2C;

    logic        Clk;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [7:0]  keycode;
    logic        is_dino;
    logic        is_obst;
    logic        game_over;
    logic [15:0] score;
    logic [9:0]  dino_y;

    int checks = 0;
    int errors = 0;

    // Model state: 0 ready, 1 playing, 2 over
    int m_state;
    int m_y;
    int m_vy;
    int m_gnd;
    int m_score;
    int m_speed;
    int m_prev;
    int m_x [2];

    runner_engine dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .keycode   (keycode),
        .is_dino   (is_dino),
        .is_obst   (is_obst),
        .game_over (game_over),
        .score     (score),
        .dino_y    (dino_y)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        m_y     = 430;
        m_vy    = 0;
        m_gnd   = 1;
        m_score = 0;
        m_speed = 2;
        m_x[0]  = 640;
        m_x[1]  = 960;
    endtask

    task automatic model_reset();
        model_init();
        m_state = 0;
        m_prev  = 0;
    endtask

    // One frame of game rules.
    task automatic model_tick(input logic [7:0] kc);
        int sp, edge_sp, hit, passed, old_score;
        sp      = (kc == SP);
        edge_sp = sp && !m_prev;
        m_prev  = sp;
        if (m_state == 0) begin
            if (edge_sp) m_state = 1;
        end else if (m_state == 2) begin
            if (edge_sp) begin
                model_init();
                m_state = 1;
            end
        end else begin
            hit = 0;
            for (int i = 0; i < 2; i++) begin
                if (m_x[i] + 15 >= 160 && m_x[i] <= 180 &&
                    m_y + 40 >= 425 && m_y <= 470) hit = 1;
            end
            if (hit) begin
                m_state = 2;
            end else begin
                if (m_gnd && sp) begin
                    m_vy  = 12;
                    m_gnd = 0;
                end
                if (!m_gnd) begin
                    int ny;
                    ny   = m_y - m_vy;
                    m_vy = m_vy - 1;
                    if (ny >= 430) begin
                        m_y   = 430;
                        m_vy  = 0;
                        m_gnd = 1;
                    end else begin
                        m_y = ny;
                    end
                end
                passed = 0;
                for (int i = 0; i < 2; i++) begin
                    if (m_x[i] <= m_speed) begin
                        m_x[i] = 639;
                        passed++;
                    end else begin
                        m_x[i] = m_x[i] - m_speed;
                    end
                end
                old_score = m_score;
                m_score   = m_score + passed;
                if (m_score > 65535) m_score = 65535;
`ifdef RUNNER_SPEEDUP_EN
                if ((m_score / 8) != (old_score / 8) && m_speed < 6) m_speed++;
`else
                if (old_score < 0) m_speed = 0;
`endif
            end
        end
    endtask

    function automatic int exp_dino(input int px, input int py);
        return (px >= 160 && px <= 180 && py >= m_y && py <= m_y + 40) ? 1 : 0;
    endfunction

    function automatic int exp_obst(input int px, input int py);
        int r;
        r = 0;
        for (int i = 0; i < 2; i++) begin
            if (m_x[i] < 640 && px >= m_x[i] && px <= m_x[i] + 15 &&
                py >= 425 && py <= 470) r = 1;
        end
        return r;
    endfunction

    task automatic probe(input string tag, input int px_in, input int py_in);
        int px, py;
        px = (px_in < 0) ? 0 : ((px_in > 1023) ? 1023 : px_in);
        py = (py_in < 0) ? 0 : ((py_in > 1023) ? 1023 : py_in);
        DrawX = 10'(px);
        DrawY = 10'(py);
        #1;
        check({tag, "_is_dino"}, int'(is_dino), exp_dino(px, py));
        check({tag, "_is_obst"}, int'(is_obst), exp_obst(px, py));
    endtask

    task automatic check_all(input string tag);
        check({tag, "_game_over"}, int'(game_over), (m_state == 2) ? 1 : 0);
        check({tag, "_score"}, int'(score), m_score);
        check({tag, "_dino_y"}, int'(dino_y), m_y);
        probe({tag, "_x0"}, m_x[0], 430);
        probe({tag, "_x0m1"}, m_x[0] - 1, 430);
        probe({tag, "_x1"}, m_x[1] + 15, 470);
        probe({tag, "_dtop"}, 170, m_y);
        probe({tag, "_dabove"}, 170, m_y - 1);
        probe({tag, "_rnd"}, int'($urandom_range(140, 660)), int'($urandom_range(340, 480)));
    endtask

    task automatic frame(input logic [7:0] kc, input string tag);
        @(posedge Clk);
        #2;
        keycode   = kc;
        frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        #2 frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        model_tick(kc);
        check_all(tag);
    endtask

    // Reset asserted between clock edges must take effect immediately.
    task automatic async_reset(input string tag);
        @(posedge Clk);
        #5;
        Reset = 1'b1;
        #1;
        model_reset();
        check({tag, "_async_dino_y"}, int'(dino_y), 430);
        check({tag, "_async_game_over"}, int'(game_over), 0);
        check({tag, "_async_score"}, int'(score), 0);
        repeat (2) @(posedge Clk);
        #2 Reset = 1'b0;
        check_all(tag);
    endtask

    initial begin
        Reset     = 1'b1;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        DrawX     = '0;
        DrawY     = '0;
        model_reset();
        repeat (3) @(posedge Clk);
        #2;
        check_all("reset");
        Reset = 1'b0;

        // Idle in READY, start, then hold space through a full jump.
        repeat (2) frame(8'h00, "ready_idle");
        frame(SP, "start");
        repeat (26) frame(SP, "jump");
        // Run into the first obstacle and stay frozen in OVER.
        repeat (330) frame(8'h00, "run_over");
        // Restart, then hold space into the next game over.
        frame(SP, "restart1");
        repeat (260) frame(SP, "held_jumps");
        frame(8'h00, "release");
        frame(SP, "restart2");
        // Reset while airborne.
        repeat (5) frame(SP, "pre_reset_jump");
        async_reset("mid_jump");
        frame(8'h00, "after_reset");

        // Randomized key traffic with occasional resets.
        for (int n = 0; n < 900; n++) begin
            logic [7:0] kc;
            if ($urandom_range(0, 399) == 0) begin
                async_reset("rnd_reset");
            end
            if ($urandom_range(0, 9) < 3) begin
                kc = SP;
            end else begin
                kc = 8'($urandom_range(0, 255));
                if (kc == SP) kc = 8'h00;
            end
            frame(kc, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
